// File: rtl/clk_div_gen.sv
// ---------------------------------------------------------------------------
// clk_div_gen
//
// Multi-channel programmable clock divider / enable generator. Each of the
// NCH channels produces a registered, glitch-free divided clock from clk.
// Each channel has its own run control and a shadowed divide ratio. A new
// ratio takes effect only on a period boundary, or one cycle after the write
// when the channel is parked.
//
// Waveform for a live ratio D (values below 2 are treated as 2):
//   the counter runs 0..D-1 and then wraps to 0,
//   clk_out is high while cnt < ceil(D/2) and low for the rest of the period.
//
// Run control:
//   - A parked channel sees en=1. On the next cycle clk_out=1, cnt=0 and
//     active=1.
//   - Dropping en never truncates a period. The channel finishes the current
//     period and parks at the wrap.
//   - If en returns before the wrap, the channel keeps running with no gap.
//
// Optional feature (macro CLK_DIV_TICK_EN):
//   When the macro is defined, the output tick[i] pulses for one cycle on the
//   first high cycle of every period. When it is undefined, the port and its
//   logic are absent.
//
// Parameters
//   NCH      number of independent channels (1..16)
//   DIV_W    width of each divide ratio
//   DEF_DIV  ratio loaded into every channel at reset (>= 2)
//
// Ports
//   clk       in   system clock; all logic runs on posedge
//   rst_n     in   asynchronous active-low reset
//   en        in   [NCH]        per-channel run request (level)
//   div_wr    in   [NCH]        per-channel write strobe for its div_in slice
//   div_in    in   [NCH*DIV_W]  channel i ratio at [i*DIV_W +: DIV_W]
//   clk_out   out  [NCH]        divided clocks (registered)
//   active    out  [NCH]        channel running or finishing its last period
//   upd_pend  out  [NCH]        shadow ratio written but not yet applied
//   tick      out  [NCH]        period-start strobe (CLK_DIV_TICK_EN only)
// ---------------------------------------------------------------------------
module clk_div_gen #(
    parameter int NCH     = 4,
    parameter int DIV_W   = 8,
    parameter int DEF_DIV = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       en,
    input  logic [NCH-1:0]       div_wr,
    input  logic [NCH*DIV_W-1:0] div_in,
    output logic [NCH-1:0]       clk_out,
    output logic [NCH-1:0]       active,
    output logic [NCH-1:0]       upd_pend
`ifdef CLK_DIV_TICK_EN
    ,
    output logic [NCH-1:0]       tick
`endif
);

    localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO   = DIV_W'(2);
    localparam logic [DIV_W-1:0] DEF_R = (DEF_DIV < 2) ? TWO : DIV_W'(DEF_DIV);

    typedef enum logic [1:0] {
        ST_PARK = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } ch_state_t;

    // Ratios of 0 and 1 cannot form a high and a low phase, so they are
    // promoted to 2.
    function automatic logic [DIV_W-1:0] sat_ratio(input logic [DIV_W-1:0] d);
        return (d < TWO) ? TWO : d;
    endfunction

    // ceil(d/2) = number of high cycles in a period of length d.
    function automatic logic [DIV_W-1:0] high_len(input logic [DIV_W-1:0] d);
        return (d >> 1) + {{(DIV_W-1){1'b0}}, d[0]};
    endfunction

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        ch_state_t        state_q, state_d;
        logic [DIV_W-1:0] cnt_q,   cnt_d;
        logic [DIV_W-1:0] live_q,  live_d;
        logic [DIV_W-1:0] shad_q,  shad_d;
        logic             pend_q,  pend_d;
        logic             clk_q,   clk_d;
        logic             act_q,   act_d;
        logic [DIV_W-1:0] wr_val;
        logic             wrap;

        assign wr_val = sat_ratio(div_in[i*DIV_W +: DIV_W]);
        assign wrap   = (cnt_q == (live_q - ONE));

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            live_d  = live_q;
            shad_d  = shad_q;
            pend_d  = pend_q;

            case (state_q)
                ST_PARK: begin
                    cnt_d = '0;
                    // A parked channel has no period to protect. Any pending
                    // shadow is applied at once.
                    if (pend_q) begin
                        live_d = shad_q;
                        pend_d = 1'b0;
                    end
                    if (en[i]) begin
                        state_d = ST_RUN;
                        // A write that arrives together with the start is
                        // used directly, so the first period already has the
                        // new ratio.
                        if (div_wr[i]) begin
                            live_d = wr_val;
                            shad_d = wr_val;
                            pend_d = 1'b0;
                        end
                    end else if (div_wr[i]) begin
                        shad_d = wr_val;
                        pend_d = 1'b1;
                    end
                end

                ST_RUN, ST_STOP: begin
                    if (wrap) begin
                        cnt_d = '0;
                        if (pend_q) begin
                            live_d = shad_q;
                            pend_d = 1'b0;
                        end
                        // The period has finished. Park only if the request
                        // is still low at the boundary.
                        state_d = en[i] ? ST_RUN : ST_PARK;
                    end else begin
                        cnt_d   = cnt_q + ONE;
                        state_d = en[i] ? ST_RUN : ST_STOP;
                    end
                    // A write in the same cycle as a wrap lands in the
                    // shadow after the old shadow has been applied, so the
                    // update stays pending.
                    if (div_wr[i]) begin
                        shad_d = wr_val;
                        pend_d = 1'b1;
                    end
                end

                default: begin
                    state_d = ST_PARK;
                    cnt_d   = '0;
                end
            endcase

            // Outputs are computed from the next state so that they are
            // registered together with it.
            act_d = (state_d != ST_PARK);
            clk_d = act_d && (cnt_d < high_len(live_d));
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_PARK;
                cnt_q   <= '0;
                live_q  <= DEF_R;
                shad_q  <= DEF_R;
                pend_q  <= 1'b0;
                clk_q   <= 1'b0;
                act_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                live_q  <= live_d;
                shad_q  <= shad_d;
                pend_q  <= pend_d;
                clk_q   <= clk_d;
                act_q   <= act_d;
            end
        end

        assign clk_out[i]  = clk_q;
        assign active[i]   = act_q;
        assign upd_pend[i] = pend_q;

`ifdef CLK_DIV_TICK_EN
        logic tick_q, tick_d;

        // Marks the first high cycle of every period, including the first
        // period after a start.
        assign tick_d = act_d && (cnt_d == '0);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tick_q <= 1'b0;
            end else begin
                tick_q <= tick_d;
            end
        end

        assign tick[i] = tick_q;
`endif
    end

endmodule

// File: tb/tb_clk_div_gen.sv
`timescale 1ns/1ps
module tb_clk_div_gen;
    localparam int NCH     = 4;
    localparam int DIV_W   = 8;
    localparam int DEF_DIV = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NCH-1:0]       en;
    logic [NCH-1:0]       div_wr;
    logic [NCH*DIV_W-1:0] div_in;
    logic [NCH-1:0]       clk_out;
    logic [NCH-1:0]       active;
    logic [NCH-1:0]       upd_pend;
`ifdef CLK_DIV_TICK_EN
    logic [NCH-1:0]       tick;
`endif

    clk_div_gen #(.NCH(NCH), .DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .div_wr   (div_wr),
        .div_in   (div_in),
        .clk_out  (clk_out),
        .active   (active),
`ifdef CLK_DIV_TICK_EN
        .tick     (tick),
`endif
        .upd_pend (upd_pend)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Each channel is running or parked. It has a phase within the period,
    // a live ratio, a shadow ratio and a pending flag. When the phase wraps,
    // a pending shadow becomes live and the channel parks if en is low.
    int m_run [NCH];
    int m_ph  [NCH];
    int m_rat [NCH];
    int m_sh  [NCH];
    int m_pd  [NCH];

    always @(posedge clk or negedge rst_n) begin : model
        int nr [NCH];
        int np [NCH];
        int nra[NCH];
        int ns [NCH];
        int npd[NCH];
        int wv;
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                m_run[c] <= 0;
                m_ph[c]  <= 0;
                m_rat[c] <= DEF_DIV;
                m_sh[c]  <= DEF_DIV;
                m_pd[c]  <= 0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                nr[c] = m_run[c]; np[c] = m_ph[c]; nra[c] = m_rat[c];
                ns[c] = m_sh[c];  npd[c] = m_pd[c];
                wv = int'(div_in[c*DIV_W +: DIV_W]);
                if (wv < 2) wv = 2;
                if (m_run[c] == 0) begin
                    if (m_pd[c] != 0) begin nra[c] = m_sh[c]; npd[c] = 0; end
                    if (en[c]) begin
                        nr[c] = 1; np[c] = 0;
                        if (div_wr[c]) begin nra[c] = wv; ns[c] = wv; npd[c] = 0; end
                    end else if (div_wr[c]) begin
                        ns[c] = wv; npd[c] = 1;
                    end
                end else begin
                    np[c] = (m_ph[c] + 1) % m_rat[c];
                    if (np[c] == 0) begin
                        if (m_pd[c] != 0) begin nra[c] = m_sh[c]; npd[c] = 0; end
                        if (!en[c]) nr[c] = 0;
                    end
                    if (div_wr[c]) begin ns[c] = wv; npd[c] = 1; end
                end
            end
            m_run <= nr; m_ph <= np; m_rat <= nra; m_sh <= ns; m_pd <= npd;
        end
    end

    // Compare every cycle, half a clock away from the active edge.
    always @(negedge clk) begin : compare
        logic [NCH-1:0] ec, ea, ep, et;
        for (int c = 0; c < NCH; c++) begin
            ea[c] = (m_run[c] != 0);
            ec[c] = (m_run[c] != 0) && (2 * m_ph[c] < m_rat[c]);
            ep[c] = (m_pd[c] != 0);
            et[c] = (m_run[c] != 0) && (m_ph[c] == 0);
        end
        check("clk_out", int'(clk_out), int'(ec));
        check("active", int'(active), int'(ea));
        check("upd_pend", int'(upd_pend), int'(ep));
`ifdef CLK_DIV_TICK_EN
        check("tick", int'(tick), int'(et));
`else
        if (et != et) $display("unreachable");
`endif
    end

    // ---------------- stimulus helpers ----------------
    logic [NCH-1:0] samp  [0:127];
    logic [NCH-1:0] act_s [0:127];
    logic [NCH-1:0] pend_s[0:127];
    logic [NCH-1:0] tick_s[0:127];

    task automatic set_div(input int c, input int v);
        div_in[c*DIV_W +: DIV_W] = DIV_W'(v);
    endtask

    // Sample the current cycle and then advance. One-shot writes end after
    // the first cycle.
    task automatic rec(input int n);
        for (int k = 0; k < n; k++) begin
            samp[k]   = clk_out;
            act_s[k]  = active;
            pend_s[k] = upd_pend;
`ifdef CLK_DIV_TICK_EN
            tick_s[k] = tick;
`else
            tick_s[k] = '0;
`endif
            @(negedge clk);
            div_wr = '0;
        end
    endtask

    // Literal shape check. Each period is hi cycles high followed by lo
    // cycles low. The bit pattern is built with the first cycle in the LSB.
    task automatic chk_pat(input string nm, input int c, input int start,
                           input int hi, input int lo, input int periods);
        for (int p = 0; p < periods; p++) begin
            int got;
            int exp;
            got = 0;
            exp = (1 << hi) - 1;
            for (int j = 0; j < hi + lo; j++)
                got |= int'(samp[start + p*(hi+lo) + j][c]) << j;
            check($sformatf("%s_p%0d", nm, p), got, exp);
        end
    endtask

    task automatic wait_phase(input int c, input int ph);
        int guard;
        guard = 0;
        while (!(m_run[c] != 0 && m_ph[c] == ph) && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        check($sformatf("wait_ph%0d_ch%0d", ph, c), int'(guard < 64), 1);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int cnt;
        int adj;
        rst_n  = 1'b1;
        en     = '1;
        div_wr = '0;
        div_in = '0;
        #1 rst_n = 1'b0;

        // Reset with every channel requested.
        repeat (3) @(negedge clk);
        check("rst_clk", int'(clk_out), 0);
        check("rst_act", int'(active), 0);
        check("rst_pend", int'(upd_pend), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("start_clk_hi", int'(clk_out), 'hF);
        check("start_act", int'(active), 'hF);
        @(negedge clk);
        check("start_clk_lo", int'(clk_out), 0);
        @(negedge clk);
        check("start_clk_hi2", int'(clk_out), 'hF);

        // Ratio shapes: the write and the start happen in the same cycle.
        en = '0;
        repeat (3) @(negedge clk);
        check("parked_all", int'(active), 0);
        set_div(0, 3); set_div(1, 5); set_div(2, 8);
        div_wr = 4'b0111;
        en     = 4'b0111;
        @(negedge clk);
        div_wr = '0;
        rec(80);
        chk_pat("d3", 0, 0, 2, 1, 10);
        chk_pat("d5", 1, 0, 3, 2, 10);
        chk_pat("d8", 2, 0, 4, 4, 10);

        // Shadow update: run at D=4 and write D=6 so that it becomes
        // pending at cnt=1.
        en[0] = 1'b0;
        repeat (4) @(negedge clk);
        set_div(0, 4); div_wr[0] = 1'b1; en[0] = 1'b1;
        @(negedge clk);
        set_div(0, 6); div_wr[0] = 1'b1;
        rec(16);
        cnt = 0;
        for (int k = 0; k < 16; k++) cnt += int'(pend_s[k][0]);
        check("pend_cycles", cnt, 3);
        chk_pat("shadow_old", 0, 0, 2, 2, 1);
        chk_pat("shadow_new", 0, 4, 3, 3, 2);

        // Clean stop: drop en at cnt=0 with D=6.
        wait_phase(0, 0);
        en[0] = 1'b0;
        rec(10);
        chk_pat("stop_last", 0, 0, 3, 3, 1);
        cnt = 0;
        for (int k = 6; k < 10; k++) cnt += int'(samp[k][0]);
        check("stop_quiet", cnt, 0);
        check("stop_act_last", int'(act_s[5][0]), 1);
        check("stop_act_park", int'(act_s[6][0]), 0);

        // Drop en at cnt=0 and raise it again at cnt=4. There is no gap.
        en[0] = 1'b1;
        @(negedge clk);
        en[0] = 1'b0;
        for (int k = 0; k < 18; k++) begin
            samp[k]  = clk_out;
            act_s[k] = active;
            if (k == 4) en[0] = 1'b1;
            @(negedge clk);
        end
        chk_pat("resume", 0, 0, 3, 3, 3);
        cnt = 0;
        for (int k = 0; k < 18; k++) cnt += int'(act_s[k][0]);
        check("resume_act", cnt, 18);

        // Degenerate ratios and last write wins on parked ch3.
        set_div(3, 0); div_wr[3] = 1'b1;
        @(negedge clk);
        set_div(3, 1);
        @(negedge clk);
        set_div(3, 7);
        @(negedge clk);
        div_wr = '0;
        check("lastwr_pend", int'(upd_pend[3]), 1);
        repeat (3) @(negedge clk);
        check("lastwr_applied", int'(upd_pend[3]), 0);
        en[3] = 1'b1;
        @(negedge clk);
        rec(14);
        chk_pat("d7", 3, 0, 4, 3, 2);
        en[3] = 1'b0;
        repeat (8) @(negedge clk);
        check("d7_parked", int'(active[3]), 0);
        set_div(3, 1); div_wr[3] = 1'b1;
        @(negedge clk);
        div_wr = '0;
        repeat (2) @(negedge clk);
        en[3] = 1'b1;
        @(negedge clk);
        rec(6);
        chk_pat("d1_as_d2", 3, 0, 1, 1, 3);

        // Reset mid-high of a D=9 channel with an update pending.
        en[1] = 1'b0;
        repeat (6) @(negedge clk);
        set_div(1, 9); div_wr[1] = 1'b1; en[1] = 1'b1;
        @(negedge clk);
        set_div(1, 3);
        @(negedge clk);
        div_wr = '0;
        @(negedge clk);
        check("d9_high", int'(clk_out[1]), 1);
        check("d9_pend", int'(upd_pend[1]), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_clk", int'(clk_out), 0);
        check("async_act", int'(active), 0);
        check("async_pend", int'(upd_pend), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_pend", int'(upd_pend), 0);
        rec(20);
        chk_pat("post_rst_def", 1, 0, 1, 1, 10);
`ifdef CLK_DIV_TICK_EN
        cnt = 0;
        adj = 0;
        for (int k = 0; k < 20; k++) begin
            cnt += int'(tick_s[k][1]);
            if (k > 0 && tick_s[k][1] && tick_s[k-1][1]) adj++;
        end
        check("tick_count", cnt, 10);
        check("tick_width", adj, 0);
`else
        adj = 0;
        cnt = 0;
`endif

        // Randomised traffic, checked by the model every cycle.
        for (int it = 0; it < 600; it++) begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(15, 0) == 0) en[c] = ~en[c];
                div_wr[c] = ($urandom_range(7, 0) == 0);
                set_div(c, int'($urandom_range(11, 0)));
            end
            if (it == 300) begin
                #3 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        div_wr = '0;
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

endmodule
